// File: rtl/crc_fcs_pkg.sv
// Shared constants and state encoding for the transmit FCS sequencer.
`timescale 1ns/1ps
package crc_fcs_pkg;
   localparam logic [31:0] CRC32_POLY    = 32'h04c11db7;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
   localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;
   localparam int          FCS_BYTES     = 4;

   typedef enum logic [1:0] {IDLE, PAYLOAD, PAD, FCS} state_e;
endpackage

// File: rtl/crc_fcs_tx_ctrl_lfsr.sv
// Combinational LFSR next-state: advances state_in by DATA_WIDTH data bits.
`timescale 1ns/1ps
module crc_fcs_tx_ctrl_lfsr #(
   parameter int                 WIDTH      = 32,
   parameter logic [WIDTH-1:0]   POLY       = 32'h04c11db7,
   parameter bit                 REVERSE    = 1'b1,
   parameter int                 DATA_WIDTH = 8
) (
   input  logic [WIDTH-1:0]      state_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [WIDTH-1:0]      state_out
);
   logic [WIDTH-1:0] poly_rev;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
      assign poly_rev[gi] = POLY[WIDTH-1-gi];
   end

   // Reflected mode shifts right and consumes data LSB first.
   always_comb begin
      logic [WIDTH-1:0] s;
      logic             fb;
      s  = state_in;
      fb = 1'b0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         if (REVERSE) begin
            fb = s[0] ^ data_in[i];
            s  = s >> 1;
            if (fb) s = s ^ poly_rev;
         end else begin
            fb = s[WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
            s  = s << 1;
            if (fb) s = s ^ POLY;
         end
      end
      state_out = s;
   end
endmodule

// File: rtl/crc_fcs_tx_ctrl.sv
// Transmit frame sequencer: forwards payload, zero-pads short frames and
// appends the inverted CRC32 FCS, least significant byte first.
`timescale 1ns/1ps
module crc_fcs_tx_ctrl
   import crc_fcs_pkg::*;
#(
   parameter bit ENABLE_PADDING   = 1'b1,
   parameter int MIN_FRAME_LENGTH = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser
);
   localparam logic [16:0] PAY_MIN = 17'(MIN_FRAME_LENGTH - FCS_BYTES);

   state_e      state_q,    state_d;
   logic [31:0] crc_q,      crc_d;
   logic [15:0] byte_cnt_q, byte_cnt_d;
   logic [1:0]  fcs_idx_q,  fcs_idx_d;
   logic [7:0]  tdata_q,    tdata_d;
   logic        tvalid_q,   tvalid_d;
   logic        tlast_q,    tlast_d;
   logic        tuser_q,    tuser_d;
   logic        run_q;

   logic        out_free;
   logic        accept;
   logic [7:0]  lfsr_data;
   logic [31:0] crc_next;
   logic [16:0] cnt_inc;
   logic [31:0] fcs_word;

   crc_fcs_tx_ctrl_lfsr #(
      .WIDTH      (32),
      .POLY       (CRC32_POLY),
      .REVERSE    (1'b1),
      .DATA_WIDTH (8)
   ) u_lfsr (
      .state_in  (crc_q),
      .data_in   (lfsr_data),
      .state_out (crc_next)
   );

   // run_q keeps tready low while rst_n is asserted even though out_free is high.
   assign out_free      = !tvalid_q || m_axis_tready;
   assign s_axis_tready = run_q && out_free && (state_q == IDLE || state_q == PAYLOAD);
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign lfsr_data     = (state_q == PAD) ? 8'h00 : s_axis_tdata;
   assign cnt_inc       = {1'b0, byte_cnt_q} + 17'd1;
   assign fcs_word      = ~crc_q;

   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      byte_cnt_d = byte_cnt_q;
      fcs_idx_d  = fcs_idx_q;
      tdata_d    = tdata_q;
      tvalid_d   = tvalid_q;
      tlast_d    = tlast_q;
      tuser_d    = tuser_q;
      if (out_free) tvalid_d = 1'b0;

      case (state_q)
         IDLE, PAYLOAD: begin
            if (accept) begin
               tdata_d    = s_axis_tdata;
               tvalid_d   = 1'b1;
               tlast_d    = 1'b0;
               tuser_d    = 1'b0;
               crc_d      = crc_next;
               byte_cnt_d = cnt_inc[16] ? 16'hFFFF : cnt_inc[15:0];
               state_d    = PAYLOAD;
               if (s_axis_tlast) begin
                  if (s_axis_tuser) begin
                     tlast_d    = 1'b1;
                     tuser_d    = 1'b1;
                     state_d    = IDLE;
                     crc_d      = CRC32_INIT;
                     byte_cnt_d = '0;
                  end else if (ENABLE_PADDING && cnt_inc < PAY_MIN) begin
                     state_d = PAD;
                  end else begin
                     state_d   = FCS;
                     fcs_idx_d = '0;
                  end
               end
            end
         end
         PAD: begin
            if (out_free) begin
               tdata_d    = 8'h00;
               tvalid_d   = 1'b1;
               tlast_d    = 1'b0;
               tuser_d    = 1'b0;
               crc_d      = crc_next;
               byte_cnt_d = cnt_inc[15:0];
               if (cnt_inc == PAY_MIN) begin
                  state_d   = FCS;
                  fcs_idx_d = '0;
               end
            end
         end
         FCS: begin
            if (out_free) begin
               tdata_d  = fcs_word[{fcs_idx_q, 3'b000} +: 8];
               tvalid_d = 1'b1;
               tlast_d  = (fcs_idx_q == 2'd3);
               tuser_d  = 1'b0;
               if (fcs_idx_q == 2'd3) begin
                  state_d    = IDLE;
                  crc_d      = CRC32_INIT;
                  byte_cnt_d = '0;
                  fcs_idx_d  = '0;
               end else begin
                  fcs_idx_d = fcs_idx_q + 2'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         crc_q      <= CRC32_INIT;
         byte_cnt_q <= '0;
         fcs_idx_q  <= '0;
         tdata_q    <= '0;
         tvalid_q   <= 1'b0;
         tlast_q    <= 1'b0;
         tuser_q    <= 1'b0;
         run_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         byte_cnt_q <= byte_cnt_d;
         fcs_idx_q  <= fcs_idx_d;
         tdata_q    <= tdata_d;
         tvalid_q   <= tvalid_d;
         tlast_q    <= tlast_d;
         tuser_q    <= tuser_d;
         run_q      <= 1'b1;
      end
   end

   assign m_axis_tdata  = tdata_q;
   assign m_axis_tvalid = tvalid_q;
   assign m_axis_tlast  = tlast_q;
   assign m_axis_tuser  = tuser_q;
endmodule

// File: tb/tb_crc_fcs_tx_ctrl.sv
// Directed bench: padded (64-byte minimum) and unpadded instances against a byte model.
`timescale 1ns/1ps
module tb_crc_fcs_tx_ctrl;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] s_tdata;
   logic       s_tvalid, s_tready, s_tlast, s_tuser;
   logic [7:0] m_tdata;
   logic       m_tvalid, m_tready, m_tlast, m_tuser;
   logic [7:0] s0_tdata;
   logic       s0_tvalid, s0_tready, s0_tlast, s0_tuser;
   logic [7:0] m0_tdata;
   logic       m0_tvalid, m0_tlast, m0_tuser;
   logic       m0_tready = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   bit rand_ready = 1'b0;

   logic [7:0] tx_buf[$];
   logic [9:0] exp_q[$];
   logic [9:0] rx_q[$];

   always #5 clk = ~clk;

   crc_fcs_tx_ctrl #(.ENABLE_PADDING(1'b1), .MIN_FRAME_LENGTH(64)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
      .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser));

   crc_fcs_tx_ctrl #(.ENABLE_PADDING(1'b0), .MIN_FRAME_LENGTH(64)) u_dut_nopad (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s0_tdata), .s_axis_tvalid(s0_tvalid), .s_axis_tready(s0_tready),
      .s_axis_tlast(s0_tlast), .s_axis_tuser(s0_tuser),
      .m_axis_tdata(m0_tdata), .m_axis_tvalid(m0_tvalid), .m_axis_tready(m0_tready),
      .m_axis_tlast(m0_tlast), .m_axis_tuser(m0_tuser));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      logic        fb;
      r = c;
      for (int i = 0; i < 8; i++) begin
         fb = r[0] ^ b[i];
         r  = r >> 1;
         if (fb) r = r ^ 32'hEDB88320;
      end
      return r;
   endfunction

   // Expected output of the padded instance for the frame in tx_buf.
   task automatic model_frame(input bit user);
      logic [31:0] c;
      logic [31:0] inv;
      int          n;
      c = 32'hFFFFFFFF;
      n = tx_buf.size();
      for (int i = 0; i < n; i++) begin
         c = crc_upd(c, tx_buf[i]);
         exp_q.push_back({(user && i == n-1) ? 2'b11 : 2'b00, tx_buf[i]});
      end
      if (!user) begin
         while (n < 60) begin
            c = crc_upd(c, 8'h00);
            exp_q.push_back(10'h000);
            n++;
         end
         inv = ~c;
         for (int k = 0; k < 4; k++)
            exp_q.push_back({1'b0, k == 3, 8'(inv >> (8*k))});
      end
   endtask

   always @(posedge clk) begin
      #1 m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Capture handshakes and check that stalled output holds.
   logic       prev_stall = 1'b0;
   logic [10:0] prev_out;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall)
            check("hold", 32'({m_tvalid, m_tuser, m_tlast, m_tdata}), 32'(prev_out));
         if (m_tvalid && m_tready) rx_q.push_back({m_tuser, m_tlast, m_tdata});
         prev_stall = m_tvalid && !m_tready;
         prev_out   = {m_tvalid, m_tuser, m_tlast, m_tdata};
      end
   end

   task automatic send_frame(input bit user);
      bit acc;
      int t;
      model_frame(user);
      for (int i = 0; i < tx_buf.size(); i++) begin
         s_tvalid = 1'b1;
         s_tdata  = tx_buf[i];
         s_tlast  = (i == tx_buf.size() - 1);
         s_tuser  = s_tlast ? user : 1'($urandom_range(0, 1));
         t = 0;
         do begin
            @(negedge clk);
            acc = s_tready;
            @(posedge clk); #1;
            t++;
         end while (!acc && t < 5000);
         if (!acc) check("accept_timeout", 32'(0), 32'(1));
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic wait_rx(input int n);
      int t;
      t = 0;
      while (rx_q.size() < n && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      if (rx_q.size() < n) check("wait_rx_timeout", 32'(rx_q.size()), 32'(n));
   endtask

   task automatic drain(input string tag, input int exp_len, input bit do_res);
      logic [31:0] r;
      int          t;
      t = 0;
      while (rx_q.size() < exp_q.size() && t < 20000) begin
         @(posedge clk);
         t++;
      end
      repeat (4) @(posedge clk);
      #1;
      check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
      if (exp_len > 0) check({tag, "_hlen"}, 32'(rx_q.size()), 32'(exp_len));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
         check(tag, 32'(rx_q[i]), 32'(exp_q[i]));
      if (do_res) begin
         r = 32'hFFFFFFFF;
         for (int i = 0; i < rx_q.size(); i++) r = crc_upd(r, rx_q[i][7:0]);
         check({tag, "_residue"}, r, 32'hDEBB20E3);
      end
      rx_q.delete();
      exp_q.delete();
   endtask

   // "123456789" through the unpadded instance; expected bytes are hand-written.
   task automatic run_nopad();
      logic [7:0] e[13];
      for (int i = 0; i < 9; i++) e[i] = 8'(8'h31 + i);
      e[9] = 8'h26; e[10] = 8'h39; e[11] = 8'hF4; e[12] = 8'hCB;
      for (int i = 0; i < 9; i++) begin
         s0_tvalid = 1'b1;
         s0_tdata  = e[i];
         s0_tlast  = (i == 8);
         s0_tuser  = 1'b0;
         @(negedge clk);
         check("np_ready", 32'(s0_tready), 32'(1));
         if (i > 0)
            check("np_latency", 32'({m0_tvalid, m0_tlast, m0_tuser, m0_tdata}), 32'({3'b100, e[i-1]}));
         @(posedge clk); #1;
      end
      s0_tvalid = 1'b0;
      s0_tlast  = 1'b0;
      for (int k = 8; k < 13; k++) begin
         @(negedge clk);
         check("np_out", 32'({m0_tvalid, m0_tlast, m0_tuser, m0_tdata}), 32'({1'b1, k == 12, 1'b0, e[k]}));
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("np_idle", 32'(m0_tvalid), 32'(0));
      @(posedge clk); #1;
   endtask

   task automatic load_ascii();
      tx_buf.delete();
      for (int i = 0; i < 9; i++) tx_buf.push_back(8'(8'h31 + i));
   endtask

   initial begin
      rst_n = 1'b0;
      s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      s0_tdata = '0; s0_tvalid = 1'b0; s0_tlast = 1'b0; s0_tuser = 1'b0;
      m_tready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_tvalid", 32'(m_tvalid), 32'(0));
      check("rst_tlast", 32'(m_tlast), 32'(0));
      check("rst_tuser", 32'(m_tuser), 32'(0));
      check("rst_tdata", 32'(m_tdata), 32'(0));
      check("rst_sready", 32'(s_tready), 32'(0));
      check("rst_sready_np", 32'(s0_tready), 32'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run_nopad();

      tx_buf = '{8'h55};
      send_frame(1'b0);
      drain("pad1", 64, 1'b1);

      tx_buf.delete();
      for (int i = 0; i < 60; i++) tx_buf.push_back(8'(i * 7 + 3));
      send_frame(1'b0);
      drain("len60", 64, 1'b1);
      tx_buf.push_back(8'hC3);
      send_frame(1'b0);
      drain("len61", 65, 1'b1);

      rand_ready = 1'b1;
      for (int f = 0; f < 20; f++) begin
         tx_buf.delete();
         for (int i = 0; i < $urandom_range(1, 200); i++) tx_buf.push_back(8'($urandom));
         send_frame(1'b0);
      end
      drain("rand", 0, 1'b0);
      rand_ready = 1'b0;

      tx_buf.delete();
      for (int i = 0; i < 10; i++) tx_buf.push_back(8'(8'hA0 + i));
      send_frame(1'b1);
      load_ascii();
      send_frame(1'b0);
      drain("abort", 74, 1'b0);

      // Reset while padding, then while sending FCS.
      tx_buf = '{8'hA5};
      send_frame(1'b0);
      wait_rx(10);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst_pad_tvalid", 32'(m_tvalid), 32'(0));
      @(posedge clk); #2;
      rst_n = 1'b1;
      rx_q.delete(); exp_q.delete();
      @(posedge clk); #1;

      tx_buf.delete();
      for (int i = 0; i < 60; i++) tx_buf.push_back(8'(i));
      send_frame(1'b0);
      wait_rx(61);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("rst_fcs_tvalid", 32'(m_tvalid), 32'(0));
      @(posedge clk); #2;
      rst_n = 1'b1;
      rx_q.delete(); exp_q.delete();
      repeat (2) @(posedge clk);
      #1;

      load_ascii();
      send_frame(1'b0);
      drain("post_rst", 64, 1'b1);
      run_nopad();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/crc_fcs_tx_ctrl.md
Name: crc_fcs_tx_ctrl

Overview:
- Transmit-side frame sequencer that owns a byte-wide CRC32 (Ethernet FCS) datapath.
- Accepts AXI-stream frames, forwards the payload, optionally zero-pads short frames to the minimum length, then appends the 4-byte inverted CRC.
- Sits between the MAC TX frame source and the PHY-side encoder.
- Sequences the combinational lfsr next-state function: reinit, advance per byte, read out, invert.

Parameters:
- ENABLE_PADDING, 1, when 1, pad frames to MIN_FRAME_LENGTH; when 0, never pad.
- MIN_FRAME_LENGTH, 64, minimum output frame length in bytes, FCS included; legal range 5..65535.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous, active-low reset.
- s_axis_tdata  input  8  payload byte.
- s_axis_tvalid  input  1  input beat valid.
- s_axis_tready  output  1  input beat accepted when high together with tvalid.
- s_axis_tlast  input  1  last payload byte of the frame.
- s_axis_tuser  input  1  abort or bad frame; sampled only on the tlast beat.
- m_axis_tdata  output  8  output byte.
- m_axis_tvalid  output  1  output beat valid.
- m_axis_tready  input  1  downstream ready.
- m_axis_tlast  output  1  last byte of the output frame.
- m_axis_tuser  output  1  frame aborted; only set together with tlast.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - state=IDLE, crc_reg=32'hFFFFFFFF, byte_cnt=0, fcs_idx=0.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tuser=0, m_axis_tdata=0, s_axis_tready=0.
- Output stage: a single register. It may load when out_free = !m_axis_tvalid || m_axis_tready. Held values stay stable while tvalid=1 and tready=0.
- Latency: an accepted input byte appears on m_axis the next cycle.
- CRC datapath:
  - lfsr instance: width 32, poly 32'h04c11db7, Galois, REVERSE=1, DATA_WIDTH=8.
  - state_in=crc_reg, data_in=current byte. On each byte emitted into the payload or pad, crc_reg <= state_out.
- s_axis_tready = out_free && (state==IDLE || state==PAYLOAD). It is combinational from registered state and m_axis_tready.
- IDLE: crc_reg=all ones, byte_cnt=0. An accepted beat is handled as in PAYLOAD, then the block moves to PAYLOAD (or resolves tlast immediately).
- PAYLOAD, on an accepted beat:
  - Register the byte with m_tlast=0 and advance crc.
  - byte_cnt saturates at 16'hFFFF.
  - On s_axis_tlast with s_axis_tuser=1: the output byte carries tlast=1, tuser=1, no pad or FCS is sent, go to IDLE.
  - On s_axis_tlast with tuser=0: if ENABLE_PADDING and byte_cnt+1 < MIN_FRAME_LENGTH-4, go to PAD; else go to FCS with fcs_idx=0.
- PAD: each out_free cycle emits 8'h00, advances crc and increments byte_cnt. Leave for FCS when byte_cnt reaches MIN_FRAME_LENGTH-4.
- FCS:
  - Each out_free cycle emits byte fcs_idx of ~crc_reg, LSB byte first (bits [7:0] first).
  - crc_reg is frozen.
  - tlast=1 on fcs_idx=3, then go to IDLE.
- Back-to-back frames: no bubble is required beyond the PAD/FCS beats. A new frame's first beat may be accepted in the cycle after the FCS tlast beat is loaded.
- Zero-length frames are impossible: every frame has at least one tlast beat with data.
- Reset asserted mid-frame: everything returns to reset values immediately, and the partial frame is dropped with no tlast emitted.
- Backpressure in any state: state, crc_reg, counters and output hold. No beat is lost or duplicated.

Decomposition:
- Package crc_fcs_pkg holds:
  - CRC32_POLY=32'h04c11db7, CRC32_INIT=32'hFFFFFFFF, CRC32_RESIDUE=32'hDEBB20E3.
  - FCS_BYTES=4.
  - State enum {IDLE, PAYLOAD, PAD, FCS}.
- Sub-module: the existing combinational lfsr, one instance. No other sub-modules.

Test Plan:
- ENABLE_PADDING=0, send ASCII "123456789" (0x31..0x39), m_tready=1 → 13 bytes out: payload, then 26 39 F4 CB. tlast only on CB, tuser=0.
- ENABLE_PADDING=1, send 1-byte frame 0x55 → 64 bytes out: 0x55, 59×0x00, 4 FCS bytes matching the model. Running CRC over all 64 output bytes (non-inverted state) equals 32'hDEBB20E3.
- Send a 60-byte and a 61-byte frame with padding enabled → exactly 64 and 65 bytes out respectively, no pad bytes.
- Random m_axis_tready (50%) over 20 back-to-back random frames of 1..200 bytes → output matches the model byte-for-byte, and output is held stable while stalled.
- 10-byte frame with tuser=1 on tlast → 10 bytes out, tlast and tuser on byte 10, no FCS. The next frame's CRC starts from all ones and is correct.
- Deassert rst_n for 1 cycle mid-PAD and once mid-FCS → m_tvalid=0 immediately. A following "123456789" frame yields FCS 26 39 F4 CB.
